// File: rtl/pwm_fade_if.sv
// Control and status bundle between a pattern controller and pwm_fade.
// The master drives requests and pattern parameters; the slave returns duty and status.
interface pwm_fade_if #(
  parameter int N = 8,
  parameter int P = 16
);
  logic         ena;
  logic         start;
  logic         stop;
  logic         loop;
  logic [N-1:0] step;
  logic [P-1:0] step_period;
  logic [P-1:0] hold_ticks;
  logic [N-1:0] duty;
  logic         busy;
  logic         done;
  logic [2:0]   state;

  modport master (
    output ena, start, stop, loop, step, step_period, hold_ticks,
    input  duty, busy, done, state
  );

  modport slave (
    input  ena, start, stop, loop, step, step_period, hold_ticks,
    output duty, busy, done, state
  );
endinterface

// File: rtl/pwm_fade.sv
// Triangle "breathing" duty sequencer (up, hold high, down, hold low) feeding pwm.
// Optional PWM_FADE_GAMMA_EN squares the level into duty (gamma 2, full scale kept).
module pwm_fade #(
  parameter int N = 8,
  parameter int P = 16
) (
  input  logic        clk,
  input  logic        rst,
  pwm_fade_if.slave   bus
);
  // start/stop are level-sampled requests, acted on only on edges where ena is high.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam logic [N-1:0] LMAX = {N{1'b1}};

  state_t       state_q, state_d;
  logic [N-1:0] level_q, level_d;
  logic [N-1:0] step_q, step_d;
  logic [N-1:0] duty_q, duty_d;
  logic [P-1:0] period_q, period_d;
  logic [P-1:0] hold_q, hold_d;
  logic [P-1:0] tick_q, tick_d;
  logic [P-1:0] hcnt_q, hcnt_d;
  logic         loop_q, loop_d;
  logic         stopf_q, stopf_d;
  logic         done_q, done_d;
  logic         tick;
  logic [N:0]   sum;
  logic [N-1:0] up_lvl;
  logic [N-1:0] dn_lvl;

  assign tick   = (state_q != IDLE) && (tick_q == period_q - 1'b1);
  assign sum    = {1'b0, level_q} + {1'b0, step_q};
  assign up_lvl = sum[N] ? LMAX : sum[N-1:0];
  assign dn_lvl = (level_q > step_q) ? level_q - step_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      level_q  <= '0;
      step_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      hold_q   <= '0;
      tick_q   <= '0;
      hcnt_q   <= '0;
      loop_q   <= 1'b0;
      stopf_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      step_q   <= step_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      hold_q   <= hold_d;
      tick_q   <= tick_d;
      hcnt_q   <= hcnt_d;
      loop_q   <= loop_d;
      stopf_q  <= stopf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    step_d   = step_q;
    period_d = period_q;
    hold_d   = hold_q;
    loop_d   = loop_q;
    stopf_d  = stopf_q;
    tick_d   = tick_q;
    hcnt_d   = hcnt_q;
    done_d   = done_q;
    if (bus.ena) begin
      done_d = 1'b0;
      tick_d = (state_q == IDLE || tick) ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE: begin
          stopf_d = 1'b0;
          if (bus.start && !bus.stop) begin
            state_d  = UP;
            step_d   = (bus.step == '0) ? N'(1) : bus.step;
            period_d = (bus.step_period == '0) ? P'(1) : bus.step_period;
            hold_d   = bus.hold_ticks;
            loop_d   = bus.loop;
          end
        end
        UP: begin
          if (bus.stop) begin
            state_d = DOWN;
            stopf_d = 1'b1;
          end else if (tick) begin
            level_d = up_lvl;
            if (up_lvl == LMAX) state_d = HOLD_HI;
          end
        end
        HOLD_HI: begin
          if (bus.stop) begin
            state_d = DOWN;
            stopf_d = 1'b1;
          end else if (tick) begin
            if (hcnt_q == hold_q) state_d = DOWN;
            else                  hcnt_d  = hcnt_q + 1'b1;
          end
        end
        DOWN: begin
          if (bus.stop) stopf_d = 1'b1;
          if (tick) begin
            level_d = dn_lvl;
            // A stop seen on this very edge already counts as sticky.
            if (dn_lvl == '0) begin
              if (stopf_d) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = HOLD_LO;
              end
            end
          end
        end
        HOLD_LO: begin
          if (bus.stop) begin
            state_d = DOWN;
            stopf_d = 1'b1;
          end else if (tick) begin
            if (hcnt_q == hold_q) begin
              if (loop_q) begin
                state_d = UP;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
        tick_d = '0;
        hcnt_d = '0;
      end
    end
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [2*N-1:0] sq;
  always_comb begin
    sq     = {{N{1'b0}}, level_d} * {{N{1'b0}}, level_d};
    duty_d = (level_d == LMAX) ? LMAX : N'(sq >> N);
  end
`else
  assign duty_d = level_d;
`endif

  assign bus.duty  = duty_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_pwm_fade.sv
// Self-checking bench for pwm_fade: per-cycle {state,busy,done,duty} compared
// against a timeline built from the pattern rules (ramps, holds, stop, freeze).
module tb_pwm_fade;
  localparam int N    = 8;
  localparam int P    = 16;
  localparam int LMAX = (1 << N) - 1;
  localparam int W    = N + 5;

  logic clk;
  logic rst;
  pwm_fade_if #(.N(N), .P(P)) bus ();

  pwm_fade #(.N(N), .P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_pass;
  int m_lvl, m_s, m_p, m_h;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [N-1:0] gam(input int lvl);
`ifdef PWM_FADE_GAMMA_EN
    if (lvl == LMAX) return N'(LMAX);
    return N'((lvl * lvl) >> N);
`else
    return N'(lvl);
`endif
  endfunction

  task automatic push(input int st, input int bsy, input int dn, input int lvl, input int cnt);
    for (int i = 0; i < cnt; i++)
      exp_q.push_back({3'(st), 1'(bsy), 1'(dn), gam(lvl)});
  endtask

  task automatic set_params(input int s, input int p, input int h);
    m_s   = (s == 0) ? 1 : s;
    m_p   = (p == 0) ? 1 : p;
    m_h   = h;
    m_lvl = 0;
    bus.step        = N'(s);
    bus.step_period = P'(p);
    bus.hold_ticks  = P'(h);
  endtask

  // Each level stays visible for one period before the next update.
  task automatic add_up();
    while (m_lvl < LMAX) begin
      push(1, 1, 0, m_lvl, m_p);
      m_lvl = (m_lvl + m_s > LMAX) ? LMAX : m_lvl + m_s;
    end
  endtask

  task automatic add_hold(input int st);
    push(st, 1, 0, m_lvl, (m_h + 1) * m_p);
  endtask

  task automatic add_down();
    while (m_lvl > 0) begin
      push(3, 1, 0, m_lvl, m_p);
      m_lvl = (m_lvl - m_s < 0) ? 0 : m_lvl - m_s;
    end
  endtask

  task automatic add_idle();
    push(0, 0, 1, 0, 1);
    push(0, 0, 0, 0, 1);
  endtask

  // driver: start pulse, then walk the expected timeline one cycle per entry
  task automatic run_exp(input string name, input int stop_at, input int frz_at);
    int j;
    logic [W-1:0] e;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    j = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", name, j), {bus.state, bus.busy, bus.done, bus.duty}, e);
      bus.stop  = (j == stop_at);
      bus.ena   = !(frz_at >= 0 && j >= frz_at && j < frz_at + 10);
      bus.start = (e[W-1 -: 3] != 3'd0) && ($urandom_range(0, 5) == 0);
      bus.step        = N'($urandom);
      bus.step_period = P'($urandom);
      bus.hold_ticks  = P'($urandom);
      bus.loop        = 1'($urandom);
      j++;
      @(posedge clk); #1;
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    bus.ena   = 1'b1;
    bus.loop  = 1'b0;
  endtask

  initial begin
    int s, p, h, ds, f;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.ena = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    bus.step = '0;
    bus.step_period = '0;
    bus.hold_ticks = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {bus.state, bus.busy, bus.done, bus.duty}, W'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_idle", {bus.state, bus.busy, bus.done, bus.duty}, W'(0));

    // linear one-shot
    set_params(64, 2, 1);
    add_up(); add_hold(2); add_down(); add_hold(4); add_idle();
    run_exp("lin", -1, -1);

    // degenerate step/period: one increment per cycle
    set_params(0, 0, 0);
    add_up(); add_hold(2); add_down(); add_hold(4); add_idle();
    run_exp("deg", -1, -1);

    // stop mid-UP at level 128 in loop mode: fade out, no restart
    set_params(64, 2, 1);
    bus.loop = 1'b1;
    push(1, 1, 0, 0, 2);
    push(1, 1, 0, 64, 2);
    push(1, 1, 0, 128, 1);
    m_lvl = 128;
    add_down(); add_idle();
    push(0, 0, 0, 0, 5);
    run_exp("stopup", 4, -1);

    // enable freeze in HOLD_HI: exit delayed by exactly 10 cycles
    set_params(128, 1, 2);
    add_up();
    f = exp_q.size() + 1;
    add_hold(2); add_down(); add_hold(4); add_idle();
    for (int i = 0; i < 10; i++) exp_q.insert(f + 1, exp_q[f]);
    run_exp("frz", -1, f);

    // loop mode: two full patterns, then stop right after re-entering UP
    set_params($urandom_range(32, 255), $urandom_range(0, 3), $urandom_range(0, 2));
    bus.loop = 1'b1;
    for (int r = 0; r < 2; r++) begin
      add_up(); add_hold(2); add_down(); add_hold(4);
    end
    ds = exp_q.size();
    push(1, 1, 0, 0, 1);
    push(3, 1, 0, 0, m_p);
    add_idle();
    run_exp("loop", ds, -1);

    // random one-shots, some with a stop during DOWN (skips HOLD_LO)
    for (int t = 0; t < 4; t++) begin
      s = $urandom_range(0, 255);
      if ($urandom_range(0, 2) == 0) s = $urandom_range(0, 4);
      p = $urandom_range(0, 3);
      h = $urandom_range(0, 3);
      set_params(s, p, h);
      add_up(); add_hold(2);
      ds = exp_q.size();
      add_down();
      if (t % 2 == 1) begin
        add_idle();
        run_exp($sformatf("rnd%0d_s%0d_p%0d_h%0d_stop", t, s, p, h), ds, -1);
      end else begin
        add_hold(4); add_idle();
        run_exp($sformatf("rnd%0d_s%0d_p%0d_h%0d", t, s, p, h), -1, -1);
      end
    end

    // start and stop together in IDLE: stop wins, no done
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_idle", {bus.state, bus.busy, bus.done, bus.duty}, W'(0));
    @(posedge clk); #1;
    check("ss_nodone", {bus.state, bus.busy, bus.done, bus.duty}, W'(0));

    // asynchronous reset mid-UP at level 128
    set_params(64, 2, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre_rst", {bus.state, bus.busy, bus.done, bus.duty}, {3'd1, 1'b1, 1'b0, gam(128)});
    #2 rst = 1'b0;
    #1;
    check("async_rst", {bus.state, bus.busy, bus.done, bus.duty}, W'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst", {bus.state, bus.busy, bus.done, bus.duty}, W'(0));
    @(posedge clk); #1;
    check("post_rst2", {bus.state, bus.busy, bus.done, bus.duty}, W'(0));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pwm_fade.md
# pwm_fade

Duty-cycle sequencer that drives the `duty` input of the `pwm` block. It generates a triangle "breathing" pattern: ramp up, hold high, ramp down, hold low. Step size, step rate and hold time are programmable, and the pattern runs either one-shot or continuously. It sits directly upstream of `pwm`, shares its clock, and its `ena` is intended to be tied to the same enable as `pwm`.

## Interface
- `N`, 8, duty/level width; must match the downstream `pwm` `N`
- `P`, 16, width of the step-period and hold counters
- `clk` input 1, system clock, rising edge
- `rst` input 1, asynchronous, active-low reset
- `ena` input 1, when low all state, counters and outputs freeze
- `start` input 1, single-cycle request to begin a pattern; sampled only in IDLE
- `stop` input 1, request a graceful fade-out to 0
- `loop` input 1, 1 = repeat pattern, 0 = one-shot; sampled at `start`
- `step` input N, level increment per update; 0 is treated as 1
- `step_period` input P, clock cycles per update (tick); 0 is treated as 1
- `hold_ticks` input P, ticks spent in each hold state
- `duty` output N, registered duty value for `pwm`
- `busy` output 1, high in any state other than IDLE
- `done` output 1, one-cycle pulse on return to IDLE
- `state` output 3, current state encoding, for debug

## Operation
- States: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.
- `step`, `step_period`, `hold_ticks` and `loop` are latched on an accepted `start`. They are not re-sampled mid-pattern.
- Tick generator: counts enabled cycles in non-IDLE states. A tick fires when the count reaches period−1, then the count clears. The count clears on every state change.
- IDLE: on `start` (and not `stop`), go to UP with level unchanged, normally 0.
- UP, on tick: level = min(level+step, 2^N−1), computed at N+1 bits to avoid wrap. On reaching 2^N−1, go to HOLD_HI.
- HOLD_HI: a hold counter counts ticks. On the tick where the hold count equals `hold_ticks`, go to DOWN. `hold_ticks`=0 means leave on the first tick.
- DOWN, on tick: level = max(level−step, 0), with no underflow. On reaching 0, go to HOLD_LO.
- HOLD_LO: same hold rule as HOLD_HI. Then go to UP if `loop`=1, else go to IDLE and pulse `done`.
- `stop` in UP, HOLD_HI or HOLD_LO: go to DOWN next cycle, with the tick count cleared. Level is preserved.
- `stop` in DOWN: the state continues, and a sticky stop flag is set.
- While the stop flag is set, level reaching 0 goes directly to IDLE (no HOLD_LO) and pulses `done`. The stop flag clears in IDLE.
- `start` while busy is ignored. `start` and `stop` in the same IDLE cycle: stop wins, the block stays IDLE, and no `done` pulse is produced.
- `ena` low: no state, level, counter or `done` change, and pending `start`/`stop` are ignored. Nothing is queued.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, level 0, `duty` 0, `busy` 0, `done` 0, counters 0, stop flag 0. Reset mid-pattern aborts immediately.
- `start` accepted at edge k: `busy`=1 and state UP after edge k.
- First level update is at edge k+period, then every period cycles.
- `duty` is registered and updates on the same edge as level. There is no extra latency.
- `done` is high for exactly the one cycle after entering IDLE.
- `stop` at edge k (active state): state DOWN after edge k. First decrement is at edge k+period.
- One-shot pattern length, in ticks: ceil((2^N−1)/step) for UP, plus `hold_ticks`+1 for HOLD_HI, plus ceil((2^N−1)/step) for DOWN, plus `hold_ticks`+1 for HOLD_LO.

## Configuration
- `PWM_FADE_GAMMA_EN` defined: `duty` = (level==2^N−1) ? 2^N−1 : (level·level)>>N. This is a perceptual gamma of 2 that keeps full scale steady high. The product is 2N bits wide and is computed from next-level before the register.
- `PWM_FADE_GAMMA_EN` not defined: `duty` = level.

## Test plan
- Reset: assert `rst`=0 mid-UP with level 128 → `duty`=0, `busy`=0 and state=0 immediately, asynchronously, with no `done` pulse.
- Linear one-shot (N=8, step=64, step_period=2, hold_ticks=1, loop=0): `start` → `duty` sequence 64,128,192,255 (saturated), held 2 ticks, then 191,127,63,0, held 2 ticks, then `done` pulse and `busy`=0. Updates occur every 2 cycles.
- Zero/degenerate inputs: step=0, step_period=0 → level increments by 1 every cycle. 255 is reached 255 cycles after `start`.
- Stop mid-UP at level 128 (step=64, loop=1) → next state DOWN; `duty` goes 64, then 0, then IDLE with a `done` pulse. The pattern does not restart.
- Enable freeze: drop `ena` for 10 cycles during HOLD_HI → `duty` stays 255, and the hold exit is delayed by exactly 10 cycles. A `start` pulse during the freeze has no effect.
- Gamma (macro defined): level 128 → `duty` 64; level 255 → `duty` 255; level 16 → `duty` 1.
